// File: rtl/mirror_mon_pkg.sv
// Shared types and helpers for the mirror_monitor checker: FSM state encoding
// and a width-generic saturating increment.
package mirror_mon_pkg;

  localparam logic [1:0] MM_ST_IDLE  = 2'd0;
  localparam logic [1:0] MM_ST_TRACK = 2'd1;
  localparam logic [1:0] MM_ST_LAG   = 2'd2;
  localparam logic [1:0] MM_ST_FAIL  = 2'd3;

  typedef enum logic [1:0] {
    ST_IDLE  = MM_ST_IDLE,
    ST_TRACK = MM_ST_TRACK,
    ST_LAG   = MM_ST_LAG,
    ST_FAIL  = MM_ST_FAIL
  } mm_state_e;

  // Increment v, holding at 2^w-1 instead of wrapping (w up to 64).
  function automatic logic [63:0] sat_inc(input logic [63:0] v, input int unsigned w);
    logic [63:0] lim;
    lim = (w >= 64) ? '1 : ((64'd1 << w) - 64'd1);
    return (v >= lim) ? lim : v + 64'd1;
  endfunction

endpackage

// File: rtl/mm_sat_counter.sv
// Saturating up-counter; a coincident inc overrides clr so the result is 1.
module mm_sat_counter
  import mirror_mon_pkg::*;
#(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] q
);

  logic [W-1:0] r_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_q <= '0;
    end else if (inc) begin
      r_q <= clr ? W'(1) : W'(sat_inc(64'(r_q), W));
    end else if (clr) begin
      r_q <= '0;
    end
  end

  assign q = r_q;

endmodule

// File: rtl/mirror_monitor.sv
// Checks that y mirrors x, tolerating up to MAX_LAG consecutive mismatches.
// Optional first-failure timestamp enabled by MIRROR_MON_TIMESTAMP_EN.
module mirror_monitor
  import mirror_mon_pkg::*;
#(
  parameter int WIDTH   = 1,
  parameter int MAX_LAG = 0,
  parameter int CNT_W   = 16,
  parameter int TS_W    = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             clr,
  input  logic [WIDTH-1:0] x,
  input  logic [WIDTH-1:0] y,
  output logic [1:0]       state,
  output logic             fail_pulse,
  output logic             err_sticky,
  output logic [CNT_W-1:0] pass_cnt,
  output logic [CNT_W-1:0] fail_cnt,
  output logic [TS_W-1:0]  first_fail_ts,
  output logic             ts_valid
);

  localparam int LAG_W = $clog2(MAX_LAG + 2);
  localparam logic [LAG_W-1:0] LAG_LIM = LAG_W'(MAX_LAG + 1);

  mm_state_e        r_state, w_state_nxt;
  logic [LAG_W-1:0] r_lag_cnt, w_lag_nxt, w_lag_inc;
  logic             w_match, w_fail, w_pass;
  logic             r_fail_pulse, r_err_sticky;

  always_comb begin
    w_state_nxt = r_state;
    w_lag_nxt   = r_lag_cnt;
    w_fail      = 1'b0;
    w_pass      = 1'b0;
    w_match     = (x == y);
    w_lag_inc   = (r_lag_cnt == LAG_LIM) ? r_lag_cnt : r_lag_cnt + 1'b1;
    if (!en) begin
      w_state_nxt = ST_IDLE;
      w_lag_nxt   = '0;
    end else if (w_match) begin
      w_state_nxt = ST_TRACK;
      w_lag_nxt   = '0;
      w_pass      = 1'b1;
    end else begin
      w_lag_nxt = w_lag_inc;
      if (w_lag_inc != LAG_LIM) begin
        w_state_nxt = ST_LAG;
      end else begin
        // Only the entry into FAIL counts; staying there is the same episode.
        w_state_nxt = ST_FAIL;
        w_fail      = (r_state != ST_FAIL);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= ST_IDLE;
      r_lag_cnt    <= '0;
      r_fail_pulse <= 1'b0;
      r_err_sticky <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_lag_cnt    <= w_lag_nxt;
      r_fail_pulse <= w_fail;
      if (w_fail) begin
        r_err_sticky <= 1'b1;
      end else if (clr) begin
        r_err_sticky <= 1'b0;
      end
    end
  end

  mm_sat_counter #(.W(CNT_W)) u_pass_cnt (
    .clk (clk),
    .rst (rst),
    .clr (clr),
    .inc (w_pass),
    .q   (pass_cnt)
  );

  mm_sat_counter #(.W(CNT_W)) u_fail_cnt (
    .clk (clk),
    .rst (rst),
    .clr (clr),
    .inc (w_fail),
    .q   (fail_cnt)
  );

  assign state      = r_state;
  assign fail_pulse = r_fail_pulse;
  assign err_sticky = r_err_sticky;

`ifdef MIRROR_MON_TIMESTAMP_EN
  logic [TS_W-1:0] r_cyc, r_ts;
  logic            r_ts_vld;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_cyc    <= '0;
      r_ts     <= '0;
      r_ts_vld <= 1'b0;
    end else begin
      r_cyc <= r_cyc + 1'b1;
      // A clear on the failing edge re-arms capture for this very failure.
      if (w_fail && (clr || !r_ts_vld)) begin
        r_ts     <= r_cyc;
        r_ts_vld <= 1'b1;
      end else if (clr) begin
        r_ts     <= '0;
        r_ts_vld <= 1'b0;
      end
    end
  end

  assign first_fail_ts = r_ts;
  assign ts_valid      = r_ts_vld;
`else
  assign first_fail_ts = '0;
  assign ts_valid      = 1'b0;
`endif

endmodule
